calib_sequencer: RTL

//  Sequences the colour-calibration unit for N_SLOTS colour-tracking targets.
//  Per request: latches the window position, pulses cal_start, waits for the

---
 rtl/calib_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/calib_sequencer.sv
// Calibration sequencer: arms the colour-calibration unit, waits for its run
// counter to advance, and stores a saturated Y/U/V threshold box per slot.
module calib_sequencer #(
  parameter  int N_SLOTS        = 4,
  parameter  int TOL_Y          = 16,
  parameter  int TOL_UV         = 12,
  parameter  int TIMEOUT_FRAMES = 8,
  parameter  int ROW_MAX        = 479,
  parameter  int COL_MAX        = 639,
  localparam int SLOT_W         = $clog2(N_SLOTS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cal_req,
  input  logic [SLOT_W-1:0]        cal_slot,
  input  logic [9:0]               win_row,
  input  logic [9:0]               win_col,
  input  logic                     cal_clear,
  input  logic                     frame_start,
  input  logic [4:0]               ctr_in,
  input  logic [7:0]               y_in,
  input  logic signed [8:0]        u_in,
  input  logic signed [8:0]        v_in,
  output logic                     cal_start,
  output logic [9:0]               c2_row,
  output logic [9:0]               c2_col,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic [N_SLOTS-1:0]       valid_mask,
  input  logic [SLOT_W-1:0]        rd_slot,
  output logic [7:0]               y_lo,
  output logic [7:0]               y_hi,
  output logic signed [8:0]        u_lo,
  output logic signed [8:0]        u_hi,
  output logic signed [8:0]        v_lo,
  output logic signed [8:0]        v_hi
);

  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [9:0]         ROW_LIM  = 10'(ROW_MAX - 9);
  localparam logic [9:0]         COL_LIM  = 10'(COL_MAX - 9);
  localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(TIMEOUT_FRAMES);
  localparam logic signed [10:0] TOL_Y_S  = 11'(TOL_Y);
  localparam logic signed [10:0] TOL_UV_S = 11'(TOL_UV);
  localparam logic signed [10:0] Y_MAX_S  = 11'sd255;
  localparam logic signed [10:0] UV_MAX_S = 11'sd255;
  localparam logic signed [10:0] UV_MIN_S = -11'sd256;
  localparam logic signed [10:0] ZERO_S   = 11'sd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_CAPTURE,
    S_COMPUTE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic                  r_cal_start;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [N_SLOTS-1:0]    r_valid;
  logic [SLOT_W-1:0]     r_slot;
  logic [9:0]            r_row;
  logic [9:0]            r_col;
  logic [4:0]            r_snap;
  logic [FC_W-1:0]       r_fcnt;
  logic [7:0]            r_y;
  logic signed [8:0]     r_u;
  logic signed [8:0]     r_v;

  logic [7:0]            r_tab_y_lo [N_SLOTS];
  logic [7:0]            r_tab_y_hi [N_SLOTS];
  logic signed [8:0]     r_tab_u_lo [N_SLOTS];
  logic signed [8:0]     r_tab_u_hi [N_SLOTS];
  logic signed [8:0]     r_tab_v_lo [N_SLOTS];
  logic signed [8:0]     r_tab_v_hi [N_SLOTS];

  logic [9:0]            w_row_clamp;
  logic [9:0]            w_col_clamp;
  logic [FC_W-1:0]       w_fcnt_inc;
  logic signed [10:0]    w_y_ext, w_u_ext, w_v_ext;
  logic signed [10:0]    w_y_lo_ext, w_y_hi_ext;
  logic signed [10:0]    w_u_lo_ext, w_u_hi_ext;
  logic signed [10:0]    w_v_lo_ext, w_v_hi_ext;
  logic [7:0]            w_y_lo, w_y_hi;
  logic signed [8:0]     w_u_lo, w_u_hi, w_v_lo, w_v_hi;

  assign w_row_clamp = (win_row > ROW_LIM) ? ROW_LIM : win_row;
  assign w_col_clamp = (win_col > COL_LIM) ? COL_LIM : win_col;
  assign w_fcnt_inc  = r_fcnt + FC_W'(1);

  // Widen to 11-bit signed so the tolerance add/subtract can never wrap.
  assign w_y_ext    = $signed({3'b000, r_y});
  assign w_u_ext    = {{2{r_u[8]}}, r_u};
  assign w_v_ext    = {{2{r_v[8]}}, r_v};
  assign w_y_lo_ext = w_y_ext - TOL_Y_S;
  assign w_y_hi_ext = w_y_ext + TOL_Y_S;
  assign w_u_lo_ext = w_u_ext - TOL_UV_S;
  assign w_u_hi_ext = w_u_ext + TOL_UV_S;
  assign w_v_lo_ext = w_v_ext - TOL_UV_S;
  assign w_v_hi_ext = w_v_ext + TOL_UV_S;

  assign w_y_lo = (w_y_lo_ext < ZERO_S)   ? 8'd0     : w_y_lo_ext[7:0];
  assign w_y_hi = (w_y_hi_ext > Y_MAX_S)  ? 8'hFF    : w_y_hi_ext[7:0];
  assign w_u_lo = (w_u_lo_ext < UV_MIN_S) ? 9'sh100  : w_u_lo_ext[8:0];
  assign w_u_hi = (w_u_hi_ext > UV_MAX_S) ? 9'sh0FF  : w_u_hi_ext[8:0];
  assign w_v_lo = (w_v_lo_ext < UV_MIN_S) ? 9'sh100  : w_v_lo_ext[8:0];
  assign w_v_hi = (w_v_hi_ext > UV_MAX_S) ? 9'sh0FF  : w_v_hi_ext[8:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cal_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_valid     <= '0;
      r_slot      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_snap      <= '0;
      r_fcnt      <= '0;
      r_y         <= '0;
      r_u         <= '0;
      r_v         <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_tab_y_lo[i] <= '0;
        r_tab_y_hi[i] <= '0;
        r_tab_u_lo[i] <= '0;
        r_tab_u_hi[i] <= '0;
        r_tab_v_lo[i] <= '0;
        r_tab_v_hi[i] <= '0;
      end
    end else begin
      r_cal_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cal_req) begin
            r_slot      <= cal_slot;
            r_row       <= w_row_clamp;
            r_col       <= w_col_clamp;
            r_cal_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ARM;
          end else if (cal_clear) begin
            r_valid <= '0;
          end
        end
        S_ARM: begin
          r_snap  <= ctr_in;
          r_fcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A counter change outranks a coincident final frame pulse.
          if (ctr_in != r_snap) begin
            r_state <= S_CAPTURE;
          end else if (frame_start) begin
            r_fcnt <= w_fcnt_inc;
            if (w_fcnt_inc == FC_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_CAPTURE: begin
          r_y     <= y_in;
          r_u     <= u_in;
          r_v     <= v_in;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_tab_y_lo[r_slot] <= w_y_lo;
          r_tab_y_hi[r_slot] <= w_y_hi;
          r_tab_u_lo[r_slot] <= w_u_lo;
          r_tab_u_hi[r_slot] <= w_u_hi;
          r_tab_v_lo[r_slot] <= w_v_lo;
          r_tab_v_hi[r_slot] <= w_v_hi;
          r_valid[r_slot]    <= 1'b1;
          r_done             <= 1'b1;
          r_busy             <= 1'b0;
          r_state            <= S_IDLE;
        end
        S_ERR: begin
          r_valid[r_slot] <= 1'b0;
          r_busy          <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cal_start   = r_cal_start;
  assign c2_row      = r_row;
  assign c2_col      = r_col;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign valid_mask  = r_valid;

  assign y_lo = r_tab_y_lo[rd_slot];
  assign y_hi = r_tab_y_hi[rd_slot];
  assign u_lo = r_tab_u_lo[rd_slot];
  assign u_hi = r_tab_u_hi[rd_slot];
  assign v_lo = r_tab_v_lo[rd_slot];
  assign v_hi = r_tab_v_hi[rd_slot];

endmodule
